// File: rtl/stream_popr_pkg.sv
// Shared types and constants for the stream pop primitive and its buffer.
package stream_popr_pkg;

  // Default element / int result width.
  localparam int INT_N = 8;

  // Depth of the remainder buffer; count saturates here.
  localparam logic [1:0] SKID_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    POPR_IDLE = 2'd0,
    POPR_HEAD = 2'd1,
    POPR_EMIT = 2'd2,
    POPR_PASS = 2'd3
  } popr_state_e;

endpackage

// File: rtl/stream_popr_skid.sv
// Two-entry registered FIFO for the remainder stream. All handshake outputs
// come from the registered count, so no input reaches a ready/valid output
// combinationally. Contents are cleared on reset so pop_data reads 0.
module stream_skid2
  import stream_popr_pkg::*;
#(
  parameter int N = INT_N
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] push_data,
  input  logic         push_valid,
  output logic         push_ready,
  output logic [N-1:0] pop_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [1:0]   count
);

  logic [N-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign push_ready = (count != SKID_DEPTH);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop_ready & pop_valid;

  // Storage, pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_popr.sv
// Stream pop: takes the head element of sIn as the int result dOut and
// forwards the remainder of the stream through a 2-entry buffer.
//
// state | meaning
// IDLE  | waiting for a call
// HEAD  | taking the first stream element into dOut
// EMIT  | presenting dOut until the caller consumes it
// PASS  | forwarding the rest of the stream; a new call drains then restarts
module stream_popr
  import stream_popr_pkg::*;
#(
  parameter int N = INT_N
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [N-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  output logic [N-1:0] dOut,
  output logic [N-1:0] sOut,
  output logic         sOut_valid,
  input  logic         sOut_ready
);

  popr_state_e state;
  logic        restart;
  logic [1:0]  count;
  logic        buf_ready;
  logic        in_pass;
  logic        buf_push;

  assign in_pass = (state == POPR_PASS) && !restart;

  // While a restart is pending a further call would be lost, so it is held off.
  assign in_ready  = nrst & ((state == POPR_IDLE) | in_pass);
  assign sIn_ready = (state == POPR_HEAD) | (in_pass & buf_ready);
  assign out_valid = (state == POPR_EMIT);
  assign buf_push  = sIn_valid & in_pass;

  stream_skid2 #(.N(N)) u_skid (
    .clk        (clk),
    .nrst       (nrst),
    .push_data  (sIn),
    .push_valid (buf_push),
    .push_ready (buf_ready),
    .pop_data   (sOut),
    .pop_valid  (sOut_valid),
    .pop_ready  (sOut_ready),
    .count      (count)
  );

  // Call sequencing, head capture and restart tracking.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= POPR_IDLE;
      restart <= 1'b0;
      dOut    <= '0;
    end else begin
      case (state)
        POPR_IDLE: begin
          if (in_valid) state <= POPR_HEAD;
        end
        POPR_HEAD: begin
          if (sIn_valid) begin
            dOut  <= sIn;
            state <= POPR_EMIT;
          end
        end
        POPR_EMIT: begin
          if (out_ready) state <= POPR_PASS;
        end
        POPR_PASS: begin
          if (restart) begin
            if (count == 2'd0) begin
              state   <= POPR_HEAD;
              restart <= 1'b0;
            end
          end else if (in_valid) begin
            restart <= 1'b1;
          end
        end
        default: state <= POPR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_popr.sv
// Bench for stream_popr: a per-cycle vector table for pop, pass-through,
// backpressure and restart, then hand sequences for stall, width and reset.
module tb_stream_popr;

  logic       clk;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sIn;
  logic       sIn_valid;
  logic       sIn_ready;
  logic [7:0] dOut;
  logic [7:0] sOut;
  logic       sOut_valid;
  logic       sOut_ready;

  int checks = 0;
  int errors = 0;

  stream_popr #(.N(8)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sIn        (sIn),
    .sIn_valid  (sIn_valid),
    .sIn_ready  (sIn_ready),
    .dOut       (dOut),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] s_in;
    logic       sv;
    logic       ordy;
    logic       sordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_dout;
    logic       e_sir;
    logic       e_sov;
    logic [7:0] e_sout;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [7:0] s_in, logic sv, logic ordy, logic sordy,
                              logic e_ir, logic e_ov, logic [7:0] e_dout, logic e_sir,
                              logic e_sov, logic [7:0] e_sout);
    vec_t v;
    v.iv = iv; v.s_in = s_in; v.sv = sv; v.ordy = ordy; v.sordy = sordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_dout = e_dout; v.e_sir = e_sir;
    v.e_sov = e_sov; v.e_sout = e_sout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nrst       = 1'b0;
    in_valid   = 1'b0;
    sIn        = 8'h00;
    sIn_valid  = 1'b0;
    out_ready  = 1'b0;
    sOut_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    // Cycle script: row k inputs are applied during cycle k; expected outputs
    // are the registered view during that cycle (after edge k).
    //              iv  sIn   sv or sor | ir ov dOut  sIr sov sOut
    vecs[0]  = mk(1, 8'd1,  1, 1, 1,   1, 0, 8'd0, 0, 0, 8'd0);
    vecs[1]  = mk(0, 8'd1,  1, 1, 1,   0, 0, 8'd0, 1, 0, 8'd0);
    vecs[2]  = mk(0, 8'd2,  1, 1, 1,   0, 1, 8'd1, 0, 0, 8'd0);
    vecs[3]  = mk(0, 8'd2,  1, 1, 1,   1, 0, 8'd1, 1, 0, 8'd0);
    vecs[4]  = mk(0, 8'd3,  1, 1, 1,   1, 0, 8'd1, 1, 1, 8'd2);
    vecs[5]  = mk(0, 8'd4,  1, 1, 1,   1, 0, 8'd1, 1, 1, 8'd3);
    vecs[6]  = mk(0, 8'd5,  1, 1, 0,   1, 0, 8'd1, 1, 1, 8'd4);
    vecs[7]  = mk(0, 8'd6,  1, 1, 0,   1, 0, 8'd1, 0, 1, 8'd4);
    vecs[8]  = mk(0, 8'd6,  1, 1, 0,   1, 0, 8'd1, 0, 1, 8'd4);
    vecs[9]  = mk(0, 8'd6,  1, 1, 0,   1, 0, 8'd1, 0, 1, 8'd4);
    vecs[10] = mk(0, 8'd6,  1, 1, 1,   1, 0, 8'd1, 0, 1, 8'd4);
    vecs[11] = mk(0, 8'd6,  1, 1, 1,   1, 0, 8'd1, 1, 1, 8'd5);
    vecs[12] = mk(0, 8'd7,  1, 1, 1,   1, 0, 8'd1, 1, 1, 8'd6);
    vecs[13] = mk(0, 8'd8,  1, 1, 0,   1, 0, 8'd1, 1, 1, 8'd7);
    vecs[14] = mk(1, 8'd9,  1, 1, 0,   1, 0, 8'd1, 0, 1, 8'd7);
    vecs[15] = mk(0, 8'd9,  1, 1, 1,   0, 0, 8'd1, 0, 1, 8'd7);
    vecs[16] = mk(0, 8'd9,  1, 1, 1,   0, 0, 8'd1, 0, 1, 8'd8);
    vecs[17] = mk(0, 8'd9,  1, 1, 1,   0, 0, 8'd1, 0, 0, 8'd0);
    vecs[18] = mk(0, 8'd9,  1, 1, 1,   0, 0, 8'd1, 1, 0, 8'd0);
    vecs[19] = mk(0, 8'd10, 1, 1, 1,   0, 1, 8'd9, 0, 0, 8'd0);
    vecs[20] = mk(0, 8'd10, 1, 1, 1,   1, 0, 8'd9, 1, 0, 8'd0);
    vecs[21] = mk(0, 8'd11, 1, 1, 1,   1, 0, 8'd9, 1, 1, 8'd10);

    // Reset values, with in_ready gated off while nrst is low.
    nrst       = 1'b0;
    in_valid   = 1'b1;
    sIn        = 8'h00;
    sIn_valid  = 1'b1;
    out_ready  = 1'b1;
    sOut_ready = 1'b1;
    #2;
    chk("rst_in_ready",   {7'd0, in_ready},   8'd0);
    chk("rst_out_valid",  {7'd0, out_valid},  8'd0);
    chk("rst_sin_ready",  {7'd0, sIn_ready},  8'd0);
    chk("rst_sout_valid", {7'd0, sOut_valid}, 8'd0);
    chk("rst_dout",       dOut,               8'd0);
    chk("rst_sout",       sOut,               8'd0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      in_valid   = vecs[i].iv;
      sIn        = vecs[i].s_in;
      sIn_valid  = vecs[i].sv;
      out_ready  = vecs[i].ordy;
      sOut_ready = vecs[i].sordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i),   {7'd0, in_ready},   {7'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_out_valid", i),  {7'd0, out_valid},  {7'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_dout", i),       dOut,               vecs[i].e_dout);
      chk($sformatf("v%0d_sin_ready", i),  {7'd0, sIn_ready},  {7'd0, vecs[i].e_sir});
      chk($sformatf("v%0d_sout_valid", i), {7'd0, sOut_valid}, {7'd0, vecs[i].e_sov});
      if (vecs[i].e_sov) chk($sformatf("v%0d_sout", i), sOut, vecs[i].e_sout);
      @(posedge clk);
      #1;
    end

    // Result stall with an all-ones head, then an all-zeros remainder element.
    do_reset();
    in_valid  = 1'b1;
    sIn       = 8'hFF;
    sIn_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_head_sin_ready", {7'd0, sIn_ready}, 8'd1);
    @(posedge clk); #1;
    sIn = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_out_valid", i), {7'd0, out_valid}, 8'd1);
      chk($sformatf("stall%0d_dout", i),      dOut,              8'hFF);
      chk($sformatf("stall%0d_sin_ready", i), {7'd0, sIn_ready}, 8'd0);
      chk($sformatf("stall%0d_in_ready", i),  {7'd0, in_ready},  8'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pass_out_valid", {7'd0, out_valid}, 8'd0);
    chk("pass_in_ready",  {7'd0, in_ready},  8'd1);
    chk("pass_sin_ready", {7'd0, sIn_ready}, 8'd1);
    @(posedge clk); #1;
    sIn = 8'h5A;
    @(negedge clk);
    chk("width_sout_valid", {7'd0, sOut_valid}, 8'd1);
    chk("width_sout",       sOut,               8'h00);
    chk("width_dout",       dOut,               8'hFF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_sin_ready", {7'd0, sIn_ready}, 8'd0);
    chk("full_sout",      sOut,              8'h00);

    // Asynchronous reset with the buffer full.
    #1;
    nrst = 1'b0;
    #1;
    chk("arst_in_ready",   {7'd0, in_ready},   8'd0);
    chk("arst_out_valid",  {7'd0, out_valid},  8'd0);
    chk("arst_sin_ready",  {7'd0, sIn_ready},  8'd0);
    chk("arst_sout_valid", {7'd0, sOut_valid}, 8'd0);
    chk("arst_dout",       dOut,               8'd0);
    chk("arst_sout",       sOut,               8'd0);
    @(posedge clk); #1;
    nrst       = 1'b1;
    in_valid   = 1'b1;
    sIn        = 8'h33;
    sOut_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready",   {7'd0, in_ready},   8'd1);
    chk("post_sout_valid", {7'd0, sOut_valid}, 8'd0);
    chk("post_out_valid",  {7'd0, out_valid},  8'd0);
    chk("post_sin_ready",  {7'd0, sIn_ready},  8'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_head_sin_ready",  {7'd0, sIn_ready},  8'd1);
    chk("post_head_sout_valid", {7'd0, sOut_valid}, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_dout", dOut, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
